booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Parametrised sequential Booth multiplier; next generation of the 4-bit fixed radix-2 datapath.
- Adds generic operand width, a per-operation signed/unsigned mode, valid/ready handshakes on input and output, a synchronous abort, and an optional radix-4 recoding.
- Sits between an operand producer and a result consumer. Multiple instances may share the clkin/reset tree.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.

Ports:
- clkin  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with the operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- abort  input  1  synchronous cancel of the current operation.
- busy  output  1  high in RUN.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  result; reads 0 whenever out_valid is low.

Behaviour:
- Reset values: in_ready=1, busy=0, out_valid=0, product=0. Reset also clears the accumulator, the multiplier register, the q(-1) bit, the iteration counter and the mode flag.
- States are IDLE, RUN and DONE. Reset forces IDLE asynchronously from any state, including mid-operation.
- IDLE:
  - Accept occurs on an edge where in_valid and in_ready are both high.
  - At accept: latch a and b, extended to the internal width (sign-extended if signed_mode=1, zero-extended if 0).
  - At accept: clear the accumulator and q(-1), load the counter with N, and go to RUN.
- Iteration count N:
  - Radix-2: internal width is WIDTH+1, N = WIDTH+1.
  - Radix-4: internal width is WIDTH+2, N = (WIDTH+2)/2.
- RUN, radix-2 step, one per edge:
  - Examine {b_lsb, q(-1)}.
  - 01: add the multiplicand. 10: subtract the multiplicand. 00/11: no operation.
  - Then arithmetic right-shift {acc, b, q(-1)} by 1. Decrement the counter.
- Accumulator is WIDTH+2 bits, sufficient for the 2x multiplicand in radix-4 without overflow.
- When the counter reaches 0 after the last step, go to DONE.
- Latency: accept at edge k gives out_valid high after edge k+N. For WIDTH=8 that is 9 cycles radix-2, 5 cycles radix-4.
- DONE:
  - product equals the low 2*WIDTH bits of the {acc, b} concatenation; this is the exact signed or unsigned product.
  - product is held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE. in_ready rises the following cycle; there is no same-edge re-accept.
- abort:
  - In RUN or DONE: go to IDLE next edge and discard the result; out_valid drops and product returns to 0.
  - In IDLE: no effect. abort has priority over accept on the same edge.
- in_valid while busy or in DONE is ignored, with no queuing. Operand changes after accept have no effect.
- The mode is frozen per operation; toggling signed_mode during RUN has no effect.
- Boundary cases:
  - The most negative signed operand times itself must give the exact positive product, e.g. -128*-128 = 0x4000.
  - An operand of 0 still takes the full N cycles; there is no early exit.

Optional Feature:
- Macro BOOTH_RADIX4_EN.
- Defined:
  - Radix-4 recoding on {b[1], b[0], q(-1)}.
  - 000/111 → 0. 001/010 → +A. 011 → +2A. 100 → -2A. 101/110 → -A.
  - Arithmetic shift by 2 per step; N = (WIDTH+2)/2.
- Undefined: radix-2 as described above, N = WIDTH+1.
- Port list and handshake are identical either way; only latency differs.

Test Plan (WIDTH=8, run in both macro builds):
- Signed mode, a=7, b=-3 (0xFD); accept, out_ready=1 → product=0xFFEB after exactly N cycles, and busy is high for N cycles.
- Unsigned mode, a=0xFF, b=0xFF → product=0xFE01. Signed mode, a=b=0x80 → product=0x4000.
- Accept 5*6, hold out_ready=0 for 10 cycles → out_valid and product=0x001E stable throughout, in_ready=0. Raise out_ready → IDLE next edge, and in_ready=1 the cycle after.
- Pulse in_valid with new operands 3 cycles into RUN → ignored, first product unchanged. Assert abort together with in_valid in IDLE → no accept.
- Assert reset 2 cycles into RUN → all outputs reset immediately (asynchronously). After release, a fresh 2*-2 gives 0xFFFC.
- Assert abort in DONE → out_valid=0 and product=0 next cycle. A subsequent a=0, b=0x55 gives 0x0000 after the full N cycles.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if: operand/result handshake bundle for booth_mult_seq
interface booth_mult_seq_if #(parameter int WIDTH = 8);
    logic in_valid, in_ready, signed_mode, abort, busy, out_valid, out_ready;
    logic [WIDTH-1:0] a, b;
    logic [2*WIDTH-1:0] product;
    modport master (
        output in_valid, signed_mode, a, b, abort, out_ready,
        input in_ready, busy, out_valid, product
    );
    modport slave (
        input in_valid, signed_mode, a, b, abort, out_ready,
        output in_ready, busy, out_valid, product
    );
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed/unsigned Booth multiplier with valid/ready handshakes
// Radix-2 by default; define BOOTH_RADIX4_EN for radix-4 recoding (halves the latency).
module booth_mult_seq #(parameter int WIDTH = 8) (
    input logic clkin,
    input logic reset,
    booth_mult_seq_if.slave bus
);
`ifdef BOOTH_RADIX4_EN
    localparam int BW = WIDTH + 2;
    localparam int SH = 2;
`else
    localparam int BW = WIDTH + 1;
    localparam int SH = 1;
`endif
    localparam int AW = WIDTH + 2;
    localparam int N = BW / SH;
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [AW-1:0] acc, mcand, acc_nx;
    logic [BW-1:0] mplr, mplr_nx;
    logic q, q_nx, in_rdy, busy_r, out_vld;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] prod, prod_nx;
    logic signed [AW:0] a1, addend, sum;
    assign a1 = {mcand[AW-1], mcand};
`ifdef BOOTH_RADIX4_EN
    logic signed [AW:0] a2;
    logic [2:0] r;
    assign a2 = {mcand, 1'b0};
    always_comb begin
        r = {mplr[1:0], q};
        addend = (r == 3'b001 || r == 3'b010) ? a1 :
                 r == 3'b011 ? a2 :
                 r == 3'b100 ? -a2 :
                 (r == 3'b101 || r == 3'b110) ? -a1 : '0;
        sum = $signed({acc[AW-1], acc}) + addend;
        acc_nx = {sum[AW], sum[AW:2]};
        mplr_nx = {sum[1:0], mplr[BW-1:2]};
        q_nx = mplr[1];
    end
`else
    always_comb begin
        addend = {mplr[0], q} == 2'b01 ? a1 : {mplr[0], q} == 2'b10 ? -a1 : '0;
        sum = $signed({acc[AW-1], acc}) + addend;
        acc_nx = sum[AW:1];
        mplr_nx = {sum[0], mplr[BW-1:1]};
        q_nx = mplr[0];
    end
`endif
    // the final product is captured from the last step's next-state value
    assign prod_nx = {acc_nx[2*WIDTH-BW-1:0], mplr_nx};
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            in_rdy <= 1'b1;
            busy_r <= 1'b0;
            out_vld <= 1'b0;
            prod <= '0;
            acc <= '0;
            mcand <= '0;
            mplr <= '0;
            q <= 1'b0;
            cnt <= '0;
        end else if (state != IDLE && bus.abort) begin
            state <= IDLE;
            in_rdy <= 1'b1;
            busy_r <= 1'b0;
            out_vld <= 1'b0;
            prod <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid && !bus.abort) begin
                    mcand <= {{(AW-WIDTH){bus.signed_mode & bus.a[WIDTH-1]}}, bus.a};
                    mplr <= {{(BW-WIDTH){bus.signed_mode & bus.b[WIDTH-1]}}, bus.b};
                    acc <= '0;
                    q <= 1'b0;
                    cnt <= CW'(N);
                    state <= RUN;
                    in_rdy <= 1'b0;
                    busy_r <= 1'b1;
                end
                RUN: begin
                    acc <= acc_nx;
                    mplr <= mplr_nx;
                    q <= q_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        busy_r <= 1'b0;
                        out_vld <= 1'b1;
                        prod <= prod_nx;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state <= IDLE;
                    out_vld <= 1'b0;
                    in_rdy <= 1'b1;
                    prod <= '0;
                end
                default: begin
                    state <= IDLE;
                    in_rdy <= 1'b1;
                    busy_r <= 1'b0;
                    out_vld <= 1'b0;
                    prod <= '0;
                end
            endcase
        end
    end
    assign bus.in_ready = in_rdy;
    assign bus.busy = busy_r;
    assign bus.out_valid = out_vld;
    assign bus.product = prod;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed vectors against an arithmetic model of the multiplier handshake
module tb_booth_mult_seq;
    localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int N = (W + 2) / 2;
`else
    localparam int N = W + 1;
`endif
    logic clkin = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int m_state = 0;
    int m_left = 0;
    logic [2*W-1:0] m_prod = '0;
    booth_mult_seq_if #(.WIDTH(W)) bus();
    booth_mult_seq #(.WIDTH(W)) dut (.clkin(clkin), .reset(reset), .bus(bus.slave));
    always #5 clkin = ~clkin;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint xi, yi, p;
        if (s) begin
            xi = longint'($signed(x));
            yi = longint'($signed(y));
        end else begin
            xi = longint'({56'd0, x});
            yi = longint'({56'd0, y});
        end
        p = xi * yi;
        return p[2*W-1:0];
    endfunction

    // 0 idle, 1 run, 2 done: the product is plain arithmetic, timing is a countdown of N
    always @(posedge clkin or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_left = 0;
            m_prod = '0;
        end else if (m_state == 0) begin
            if (bus.in_valid && !bus.abort) begin
                m_prod = mul(bus.a, bus.b, bus.signed_mode);
                m_left = N;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (bus.abort) m_state = 0;
            else begin
                m_left--;
                if (m_left == 0) m_state = 2;
            end
        end else if (bus.abort || bus.out_ready) m_state = 0;
    end

    always @(negedge clkin) begin
        if (!reset) begin
            check("model_in_ready", 32'(bus.in_ready), 32'(m_state == 0));
            check("model_busy", 32'(bus.busy), 32'(m_state == 1));
            check("model_out_valid", 32'(bus.out_valid), 32'(m_state == 2));
            check("model_product", 32'(bus.product), m_state == 2 ? 32'(m_prod) : 32'd0);
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic [2*W-1:0] exp, input string nm,
                         input bit disturb, input int hold, input bit abort_done);
        int c;
        @(negedge clkin);
        bus.a = x;
        bus.b = y;
        bus.signed_mode = s;
        bus.in_valid = 1'b1;
        @(negedge clkin);
        bus.in_valid = 1'b0;
        c = 0;
        while (!bus.out_valid && c < 50) begin
            if (bus.busy) c++;
            if (disturb && c == 3) begin
                bus.in_valid = 1'b1;
                bus.a = 8'h11;
                bus.b = 8'h22;
                bus.signed_mode = ~s;
            end else bus.in_valid = 1'b0;
            @(negedge clkin);
        end
        bus.in_valid = 1'b0;
        check({nm, "_latency"}, 32'(c), 32'(N));
        check({nm, "_product"}, 32'(bus.product), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clkin);
            check({nm, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({nm, "_hold_product"}, 32'(bus.product), 32'(exp));
            check({nm, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        if (abort_done) bus.abort = 1'b1;
        else bus.out_ready = 1'b1;
        @(negedge clkin);
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        check({nm, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check({nm, "_post_product"}, 32'(bus.product), 32'd0);
        check({nm, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clkin);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_product", 32'(bus.product), 32'd0);
        reset = 1'b0;
        do_op(8'd7, 8'hFD, 1'b1, 16'hFFEB, "s7xm3", 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "uffxff", 1'b0, 0, 1'b0);
        do_op(8'h80, 8'h80, 1'b1, 16'h4000, "minxmin", 1'b0, 0, 1'b0);
        do_op(8'd5, 8'd6, 1'b0, 16'h001E, "hold", 1'b0, 10, 1'b0);
        do_op(8'hFF, 8'h02, 1'b0, 16'h01FE, "ignore_busy", 1'b1, 0, 1'b0);
        @(negedge clkin);
        bus.abort = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clkin);
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_idle_busy", 32'(bus.busy), 32'd0);
        bus.a = 8'd3;
        bus.b = 8'd4;
        bus.signed_mode = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clkin);
        bus.in_valid = 1'b0;
        @(negedge clkin);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_product", 32'(bus.product), 32'd0);
        @(negedge clkin);
        reset = 1'b0;
        do_op(8'd2, 8'hFE, 1'b1, 16'hFFFC, "s2xm2", 1'b0, 0, 1'b0);
        do_op(8'd9, 8'd4, 1'b1, 16'h0024, "abort_done", 1'b0, 0, 1'b1);
        do_op(8'd0, 8'h55, 1'b0, 16'h0000, "zero", 1'b0, 0, 1'b0);
        repeat (2) @(negedge clkin);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
